// File: rtl/logic_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_pkg : opcode encodings and buffer depth for logic_unit_pipe   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam int BUF_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/logic_unit_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_buf : 2-entry valid/ready FIFO, ready derived from occupancy  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module logic_unit_buf
    import logic_unit_pkg::*;
#(
    parameter int                DATA_W  = 10,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    localparam int               PTR_W = $clog2(BUF_DEPTH);
    localparam int               CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(BUF_DEPTH);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    // Ready depends only on registered occupancy, never on out_ready_i
    assign in_ready_o  = (cnt_q != FULL);
    assign out_valid_o = (cnt_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_pipe : 8-op bitwise logic unit with flags, op counter and a   |
// |                   2-entry decoupling result buffer                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic               out_zero,
    output logic               out_parity,
    output logic [COUNT_W-1:0] op_count
);

    localparam int               ENTRY_W = WIDTH + 2;
    // Empty head must read as y=0, zero=1, parity=0
    localparam logic [ENTRY_W-1:0] ENTRY_RST = {1'b0, 1'b1, {WIDTH{1'b0}}};

    logic [WIDTH-1:0]   res_y;
    logic               res_zero;
    logic               res_parity;
    logic [ENTRY_W-1:0] head;
    logic [COUNT_W-1:0] op_count_q, op_count_d;
    logic               accept;

    always_comb begin
        res_y = '0;
        case (in_op)
            OP_AND:  res_y = in_a & in_b;
            OP_OR:   res_y = in_a | in_b;
            OP_NOT:  res_y = ~in_a;
            OP_XOR:  res_y = in_a ^ in_b;
            OP_NAND: res_y = ~(in_a & in_b);
            OP_NOR:  res_y = ~(in_a | in_b);
            OP_XNOR: res_y = ~(in_a ^ in_b);
            OP_PASS: res_y = in_a;
            default: res_y = '0;
        endcase
    end

    assign res_zero   = (res_y == '0);
    assign res_parity = ^res_y;
    assign accept     = in_valid && in_ready;

    always_comb begin
        op_count_d = op_count_q;
        if (accept) op_count_d = op_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_count_q <= '0;
        else        op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;

    logic_unit_buf #(
        .DATA_W  (ENTRY_W),
        .RST_VAL (ENTRY_RST)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({res_parity, res_zero, res_y}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (head)
    );

    assign out_parity = head[ENTRY_W-1];
    assign out_zero   = head[WIDTH];
    assign out_y      = head[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_logic_unit_pipe : scoreboard bench for logic_unit_pipe                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [2:0] in_op = 3'd0;
    logic [7:0] in_a = 8'h00, in_b = 8'h00, out_y, op_count;
    logic       out_zero, out_parity;

    logic       in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b1;
    logic [2:0] in_op3 = 3'd0, op_count3;
    logic [7:0] a3 = 8'h00, b3 = 8'h00, out_y3;
    logic       out_zero3, out_parity3;

    logic [9:0] sb [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
        .out_parity(out_parity), .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_op(in_op3), .in_a(a3), .in_b(b3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_y(out_y3), .out_zero(out_zero3),
        .out_parity(out_parity3), .op_count(op_count3)
    );

    // Expected entry {parity, zero, y} built from the result value
    function automatic logic [9:0] mkexp(input logic [7:0] y);
        return {^y, (y == 8'h00), y};
    endfunction

    // Present an op; its expectation is queued only if it is accepted this edge
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [9:0] e);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        if (in_ready) sb.push_back(e);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_valid3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({out_valid, in_ready, out_y, out_zero, out_parity, op_count} !== {1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b rdy=%b y=%h z=%b p=%b cnt=%0d, want v=0 rdy=1 y=00 z=1 p=0 cnt=0",
                     out_valid, in_ready, out_y, out_zero, out_parity, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_opcodes();
        logic [7:0] tbl [8] = '{8'h30, 8'hFC, 8'h0F, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0};
        logic [9:0] e;
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_tests++;
                if (!out_valid || sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL opcode_latency op=%0d: out_valid=%b, want 1", i - 1, out_valid);
                end else begin
                    e = sb.pop_front();
                    if ({out_parity, out_zero, out_y} !== e) begin
                        n_fail++;
                        $display("FAIL opcode_result op=%0d: got p=%b z=%b y=%h, want p=%b z=%b y=%h",
                                 i - 1, out_parity, out_zero, out_y, e[9], e[8], e[7:0]);
                    end
                end
            end
            if (i < 8) send(3'(i), 8'hF0, 8'h3C, {1'b0, 1'b0, tbl[i]});
            else in_valid = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || op_count !== 8'd8) begin
            n_fail++;
            $display("FAIL opcode_drain: got v=%b cnt=%0d, want v=0 cnt=8", out_valid, op_count);
        end
    endtask

    task automatic test_flags();
        logic [9:0] e;
        out_ready = 1'b1;
        @(negedge clk);
        send(3'd0, 8'hAA, 8'h55, 10'b0_1_00000000);
        @(negedge clk);
        send(3'd3, 8'h01, 8'h00, 10'b1_0_00000001);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (!out_valid || sb.size() == 0) begin
                n_fail++;
                $display("FAIL flags_valid %0d: out_valid=%b, want 1", k, out_valid);
            end else begin
                e = sb.pop_front();
                if ({out_parity, out_zero, out_y} !== e) begin
                    n_fail++;
                    $display("FAIL flags_result %0d: got p=%b z=%b y=%h, want p=%b z=%b y=%h",
                             k, out_parity, out_zero, out_y, e[9], e[8], e[7:0]);
                end
            end
            if (k == 0) @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b want 1", in_ready); end
        send(3'd1, 8'h01, 8'h02, mkexp(8'h03));
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid, out_y} !== {1'b1, 1'b1, 8'h03}) begin
            n_fail++;
            $display("FAIL bp_one: got rdy=%b v=%b y=%h, want rdy=1 v=1 y=03", in_ready, out_valid, out_y);
        end
        send(3'd1, 8'h04, 8'h08, mkexp(8'h0C));
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
        send(3'd1, 8'h10, 8'h20, mkexp(8'h30));
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || sb.size() != 2 || out_y !== 8'h03) begin
            n_fail++;
            $display("FAIL bp_hold: got rdy=%b queued=%0d y=%h, want rdy=0 queued=2 y=03", in_ready, sb.size(), out_y);
        end
        out_ready = 1'b1;
        send(3'd1, 8'h10, 8'h20, mkexp(8'h30));
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin
                n_tests++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
                send(3'd1, 8'h10, 8'h20, mkexp(8'h30));
            end
            if (k == 2) in_valid = 1'b0;
            n_tests++;
            if (!out_valid || sb.size() == 0) begin
                n_fail++;
                $display("FAIL bp_drain %0d: out_valid=%b queued=%0d, want valid and queued", k, out_valid, sb.size());
            end else begin
                e = sb.pop_front();
                if (out_y !== e[7:0]) begin
                    n_fail++;
                    $display("FAIL bp_order %0d: got y=%h want y=%h", k, out_y, e[7:0]);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%b queued=%0d, want v=0 queued=0", out_valid, sb.size());
        end
    endtask

    task automatic test_streaming();
        logic [7:0] a, b;
        logic [9:0] e;
        int         bad = 0;
        rst_pulse();
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (!out_valid || sb.size() == 0) bad++;
                else begin
                    e = sb.pop_front();
                    if ({out_parity, out_zero, out_y} !== e) bad++;
                end
            end
            if (i < 20) begin
                a = 8'($urandom);
                b = 8'($urandom);
                send(3'd3, a, b, mkexp(a ^ b));
            end else in_valid = 1'b0;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream_results: got %0d bad/missing cycles, want 0", bad);
        end
        @(negedge clk);
        n_tests++;
        if (op_count !== 8'd20 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_count: got cnt=%0d v=%b, want cnt=20 v=0", op_count, out_valid);
        end
    endtask

    task automatic test_count_wrap();
        logic [2:0] seq [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        rst_pulse();
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        in_op3     = 3'd7;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a3 = 8'(i);
            n_tests++;
            if (op_count3 !== seq[i]) begin
                n_fail++;
                $display("FAIL count_wrap step %0d: got %0d want %0d", i, op_count3, seq[i]);
            end
        end
        in_valid3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        rst_pulse();
        out_ready = 1'b0;
        @(negedge clk);
        send(3'd1, 8'h01, 8'h02, mkexp(8'h03));
        @(negedge clk);
        send(3'd1, 8'h04, 8'h08, mkexp(8'h0C));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, out_y, out_zero, out_parity, op_count} !== {1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b rdy=%b y=%h z=%b p=%b cnt=%0d, want v=0 rdy=1 y=00 z=1 p=0 cnt=0",
                     out_valid, in_ready, out_y, out_zero, out_parity, op_count);
        end
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(3'd2, 8'h0F, 8'hAA, 10'b0_0_11110000);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (!out_valid || sb.size() == 0) begin
            n_fail++;
            $display("FAIL reset_fresh_valid: out_valid=%b, want 1", out_valid);
        end else begin
            e = sb.pop_front();
            if ({out_parity, out_zero, out_y} !== e) begin
                n_fail++;
                $display("FAIL reset_fresh_result: got p=%b z=%b y=%h, want p=%b z=%b y=%h",
                         out_parity, out_zero, out_y, e[9], e[8], e[7:0]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_no_stale: got v=%b cnt=%0d, want v=0 cnt=1", out_valid, op_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_opcodes();
        test_flags();
        test_back_to_back();
        test_streaming();
        test_count_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
